// File: rtl/pipe_reg.sv
// Parameterised pipeline register: DEPTH stages of data+valid with stall, flush
// and bubble insertion, plus a registered occupancy counter and stall counter.
module pipe_reg #(
  parameter int                 WIDTH   = 32,
  parameter int                 DEPTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] datain,
  input  logic             valid_in,
  output logic [WIDTH-1:0] dataout,
  output logic             valid_out,
  output logic [3:0]       occ,
  output logic [15:0]      stall_cnt
);

  // Stage 0 occupies the least-significant slot; stage DEPTH-1 drives the outputs.
  typedef logic [DEPTH-1:0][WIDTH-1:0] stages_t;

  stages_t          data_q,      data_d;
  logic [DEPTH-1:0] valid_q,     valid_d;
  logic [3:0]       occ_q,       occ_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;

  logic [WIDTH-1:0] stage0_data;
  logic             last_valid;

  assign last_valid  = valid_q[DEPTH-1];
  assign stage0_data = valid_in ? datain : RST_VAL;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    data_d      = data_q;
    valid_d     = valid_q;
    occ_d       = occ_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      data_d  = {DEPTH{RST_VAL}};
      valid_d = '0;
      occ_d   = '0;
    end else if (en) begin
      // Shift by prepending stage 0; the cast drops the old last stage.
      data_d  = stages_t'({data_q, stage0_data});
      valid_d = DEPTH'({valid_q, valid_in});
      if (valid_in && !last_valid) begin
        occ_d = occ_q + 4'd1;
      end else if (!valid_in && last_valid) begin
        occ_d = occ_q - 4'd1;
      end
    end else if ((occ_q != 4'd0) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // clr outranks flush and en, so it is applied here rather than in the next-state logic.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (clr) begin
      data_q      <= {DEPTH{RST_VAL}};
      valid_q     <= '0;
      occ_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      occ_q       <= occ_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dataout   = data_q[DEPTH-1];
  assign valid_out = valid_q[DEPTH-1];
  assign occ       = occ_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_reg.sv
// Directed self-checking bench for pipe_reg at WIDTH=32, DEPTH=3, RST_VAL=0.
module tb_pipe_reg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             clr, en, flush, valid_in;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout;
  logic             valid_out;
  logic [3:0]       occ;
  logic [15:0]      stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL('0)) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .flush     (flush),
    .datain    (datain),
    .valid_in  (valid_in),
    .dataout   (dataout),
    .valid_out (valid_out),
    .occ       (occ),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One rising edge; outputs are settled 1 time unit later and inputs change there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic v, input logic [31:0] d);
    en       = e;
    valid_in = v;
    datain   = d;
  endtask

  logic [31:0] s_din  [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [31:0] s_dout [7] = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h0};
  logic        s_vout [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0]  s_occ  [7] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};

  logic        b_vin  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] b_din  [6] = '{32'h5, 32'hFF, 32'h7, 32'h0, 32'h0, 32'h0};
  logic [31:0] b_dout [6] = '{32'h0, 32'h0, 32'h5, 32'h0, 32'h7, 32'h0};
  logic        b_vout [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0]  b_occ  [6] = '{4'd1, 4'd1, 4'd2, 4'd1, 4'd1, 4'd0};

  initial begin
    clr = 1'b1; flush = 1'b0;
    drive(1'b0, 1'b0, '0);
    tick();
    check("rst_dout",  dataout,   32'h0);
    check("rst_vout",  valid_out, 32'h0);
    check("rst_occ",   occ,       32'h0);
    check("rst_stall", stall_cnt, 32'h0);
    clr = 1'b0;

    // Streaming four words, then draining with bubbles.
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1'b1, 1'b1, s_din[i]);
      else       drive(1'b1, 1'b0, 32'h0);
      tick();
      check($sformatf("stream_dout%0d", i), dataout,   s_dout[i]);
      check($sformatf("stream_vout%0d", i), valid_out, {31'b0, s_vout[i]});
      check($sformatf("stream_occ%0d", i),  occ,       {28'b0, s_occ[i]});
    end
    check("stream_stall", stall_cnt, 32'h0);

    // Stall with two words in flight.
    drive(1'b1, 1'b1, 32'hA); tick();
    drive(1'b1, 1'b1, 32'hB); tick();
    drive(1'b0, 1'b1, 32'hC);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_vout%0d", i), valid_out, 32'h0);
      check($sformatf("stall_occ%0d", i),  occ,       32'h2);
      check($sformatf("stall_cnt%0d", i),  stall_cnt, i + 1);
    end
    drive(1'b1, 1'b0, 32'h0); tick();
    check("resume_dout", dataout,   32'hA);
    check("resume_vout", valid_out, 32'h1);
    check("resume_occ",  occ,       32'h2);
    tick();
    check("resume_dout2", dataout, 32'hB);
    check("resume_occ2",  occ,     32'h1);
    tick();
    check("resume_vout3", valid_out, 32'h0);
    check("resume_occ3",  occ,       32'h0);

    // Bubble pattern 1,0,1.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, b_vin[i], b_din[i]);
      tick();
      check($sformatf("bub_dout%0d", i), dataout,   b_dout[i]);
      check($sformatf("bub_vout%0d", i), valid_out, {31'b0, b_vout[i]});
      check($sformatf("bub_occ%0d", i),  occ,       {28'b0, b_occ[i]});
    end
    check("bub_stall", stall_cnt, 32'h5);

    // Flush beats a simultaneous stall on a full pipeline.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b1, i); tick();
    end
    check("full_dout", dataout, 32'h1);
    check("full_occ",  occ,     32'h3);
    drive(1'b0, 1'b1, 32'h99); flush = 1'b1; tick();
    flush = 1'b0;
    check("flush_vout",  valid_out, 32'h0);
    check("flush_dout",  dataout,   32'h0);
    check("flush_occ",   occ,       32'h0);
    check("flush_stall", stall_cnt, 32'h5);
    tick();
    check("empty_stall", stall_cnt, 32'h5);

    // clr outranks flush and en; the colliding word must never surface.
    drive(1'b1, 1'b1, 32'h77); tick();
    drive(1'b1, 1'b1, 32'h78); tick();
    drive(1'b0, 1'b0, 32'h0);  tick();
    check("pre_clr_stall", stall_cnt, 32'h6);
    clr = 1'b1; flush = 1'b1;
    drive(1'b1, 1'b1, 32'hDEAD); tick();
    clr = 1'b0; flush = 1'b0;
    check("clr_dout",  dataout,   32'h0);
    check("clr_vout",  valid_out, 32'h0);
    check("clr_occ",   occ,       32'h0);
    check("clr_stall", stall_cnt, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_clr_dout%0d", i), dataout,   32'h0);
      check($sformatf("post_clr_vout%0d", i), valid_out, 32'h0);
    end

    // Saturation of the stall counter.
    drive(1'b1, 1'b1, 32'h42); tick();
    drive(1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 65540; i++) begin
      tick();
      if (i == 65534) check("sat_fffe", stall_cnt, 32'hFFFE);
      if (i == 65535) check("sat_ffff", stall_cnt, 32'hFFFF);
    end
    check("sat_hold", stall_cnt, 32'hFFFF);
    check("sat_occ",  occ,       32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
